// File: rtl/zeta_pow_gen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | zgen_pkg : shared constants and FSM state type for the ZETA power source |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package zgen_pkg;

    localparam int unsigned Q         = 3329;
    localparam int unsigned BARRETT_M = 5039;
    localparam int unsigned BARRETT_K = 24;
    localparam int unsigned DATA_W    = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT    = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/zeta_pow_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | zeta_pow_gen_if : twiddle stream (value, index, valid/ready)             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface zeta_pow_gen_if
    import zgen_pkg::*;
#(
    parameter int unsigned IDX_W = 6
) ();

    logic [DATA_W-1:0] w_out;
    logic              w_valid;
    logic              w_ready;
    logic [IDX_W-1:0]  w_idx;

    modport master (output w_out, output w_valid, output w_idx, input  w_ready);
    modport slave  (input  w_out, input  w_valid, input  w_idx, output w_ready);

endinterface
`default_nettype wire

// File: rtl/zeta_pow_gen_modmul.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | zgen_modmul : 3-stage a*ZETA mod Q (multiply | Barrett qh | sub+correct) |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module zgen_modmul
    import zgen_pkg::*;
#(
    parameter int unsigned ZETA = 17
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              in_valid,
    input  wire logic [DATA_W-1:0] in_a,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_r
);

    localparam logic [23:0] c_zeta = 24'(ZETA);

    logic [23:0] r_p;
    logic        r_v1;
    logic [12:0] r_qh;
    logic [12:0] r_plo;
    logic        r_v2;
    logic [12:0] w_r;

    // True remainder lies in [0, 2Q) < 2^13, so 13-bit wraparound arithmetic is exact.
    assign w_r = r_plo - 13'(r_qh * 13'(Q));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            out_valid <= 1'b0;
            r_p       <= '0;
            r_qh      <= '0;
            r_plo     <= '0;
            out_r     <= '0;
        end else begin
            r_v1      <= in_valid;
            r_p       <= 24'(in_a) * c_zeta;
            r_v2      <= r_v1;
            r_qh      <= 13'((37'(r_p) * 37'(BARRETT_M)) >> BARRETT_K);
            r_plo     <= r_p[12:0];
            out_valid <= r_v2;
            out_r     <= (w_r >= 13'(Q)) ? 12'(w_r - 13'(Q)) : w_r[11:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/zeta_pow_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | zeta_pow_gen : streams ZETA^k mod Q for k = 0..COUNT-1, one per transfer |
// | ZGEN_BITREV_IDX_EN : w_idx carries bit-reversed k instead of natural k   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module zeta_pow_gen
    import zgen_pkg::*;
#(
    parameter int unsigned ZETA  = 17,
    parameter int unsigned COUNT = 64,
    parameter int unsigned IDX_W = $clog2(COUNT)
) (
    input  wire logic       clock,
    input  wire logic       reset,
    input  wire logic       start,
    output logic            busy,
    output logic            done,
    zeta_pow_gen_if.master  wif
);

    localparam logic [IDX_W-1:0] c_last = IDX_W'(COUNT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [IDX_W-1:0]  r_k;
    logic [1:0]        r_wait;
    logic [DATA_W-1:0] r_acc;
    logic [IDX_W-1:0]  w_idx_map;
    logic              w_xfer;
    logic              w_last;
    logic              w_launch;
    logic              w_mm_valid;
    logic              w_mm_done;
    logic [DATA_W-1:0] w_mm_r;

    assign w_xfer    = (r_state == EMIT) && wif.w_ready;
    assign w_last    = (r_k == c_last);
    assign w_launch  = w_xfer && !w_last;
    assign w_mm_done = (r_state == COMPUTE) && (r_wait == 2'd2) && w_mm_valid;

    zgen_modmul #(.ZETA(ZETA)) u_modmul (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (w_launch),
        .in_a      (r_acc),
        .out_valid (w_mm_valid),
        .out_r     (w_mm_r)
    );

`ifdef ZGEN_BITREV_IDX_EN
    for (genvar gi = 0; gi < IDX_W; gi++) begin : g_bitrev
        assign w_idx_map[gi] = r_k[IDX_W-1-gi];
    end
`else
    assign w_idx_map = r_k;
`endif

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start)     w_next = EMIT;
            EMIT:    if (w_xfer)    w_next = w_last ? DONE : COMPUTE;
            COMPUTE: if (w_mm_done) w_next = EMIT;
            DONE:                   w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state != IDLE);
        done        = (r_state == DONE);
        wif.w_valid = (r_state == EMIT);
        wif.w_out   = '0;
        wif.w_idx   = '0;
        if (r_state == EMIT) begin
            wif.w_out = r_acc;
            wif.w_idx = w_idx_map;
        end
    end

    // Counter/accumulator only move on a transfer or a finished modmul, so a stall freezes them.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc  <= DATA_W'(1);
            r_k    <= '0;
            r_wait <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc <= DATA_W'(1);
                        r_k   <= '0;
                    end
                end
                EMIT: begin
                    if (w_launch) begin
                        r_k    <= r_k + IDX_W'(1);
                        r_wait <= '0;
                    end
                end
                COMPUTE: begin
                    r_wait <= r_wait + 2'd1;
                    if (w_mm_done) r_acc <= w_mm_r;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_zeta_pow_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_zeta_pow_gen : scoreboard bench for the ZETA power generator          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_zeta_pow_gen;

    localparam int c_zeta  = 17;
    localparam int c_count = 64;
    localparam int c_idx_w = 6;
    localparam int c_q     = 3329;

    typedef struct {
        int val;
        int idx;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   n_xfer = 0;
    exp_t exp_q[$];

    zeta_pow_gen_if #(.IDX_W(c_idx_w)) wif ();

    zeta_pow_gen #(.ZETA(c_zeta), .COUNT(c_count), .IDX_W(c_idx_w)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .wif   (wif)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_idx(input int k);
        int r;
        r = k;
`ifdef ZGEN_BITREV_IDX_EN
        r = 0;
        for (int b = 0; b < c_idx_w; b++)
            if (((k >> b) & 1) != 0) r = r | (1 << (c_idx_w - 1 - b));
`endif
        return r;
    endfunction

    // Reference: successive powers of ZETA reduced mod Q with plain integer arithmetic.
    task automatic push_expected();
        int v;
        exp_t e;
        v = 1;
        for (int k = 0; k < c_count; k++) begin
            e.val = v;
            e.idx = exp_idx(k);
            exp_q.push_back(e);
            v = (v * c_zeta) % c_q;
        end
    endtask

    always @(negedge clock) begin
        if (wif.w_valid && wif.w_ready) begin
            n_xfer++;
            chk("w_out_in_range", int'(wif.w_out < 12'(c_q)), 1);
            if (exp_q.size() == 0) begin
                chk("unexpected_transfer", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_w_out", int'(wif.w_out), e.val);
                chk("sb_w_idx", int'(wif.w_idx), e.idx);
            end
        end
    end

    // mode 1: ready high + ignored start at k=10; mode 2: stall at k=2 then random; mode 3: random
    task automatic do_run(input int mode);
        int t;
        int done_n;
        int done_c;
        int x0;
        bit fin;
        push_expected();
        x0     = n_xfer;
        done_n = 0;
        done_c = 0;
        fin    = 1'b0;
        @(posedge clock); #1;
        start       = 1'b1;
        wif.w_ready = 1'b1;
        t           = cyc;
        for (int i = 1; i < 3000 && !fin; i++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (mode == 1) begin
                if (cyc == t + 41) start = 1'b1;
                if (cyc == t + 1) begin
                    chk("first_valid", int'(wif.w_valid), 1);
                    chk("first_w_out", int'(wif.w_out), 1);
                    chk("busy_after_start", int'(busy), 1);
                end
                if (cyc == t + 2) chk("compute_gap_valid", int'(wif.w_valid), 0);
                if (cyc == t + 5) chk("second_w_out", int'(wif.w_out), 17);
                if (cyc == t + 253) begin
                    chk("last_valid", int'(wif.w_valid), 1);
                    chk("last_w_out", int'(wif.w_out), 885);
                    chk("last_w_idx", int'(wif.w_idx), 63);
                end
            end else if (mode == 2) begin
                if (cyc >= t + 9 && cyc <= t + 13) begin
                    wif.w_ready = 1'b0;
                    chk("stall_valid", int'(wif.w_valid), 1);
                    chk("stall_w_out", int'(wif.w_out), 289);
                    chk("stall_w_idx", int'(wif.w_idx), exp_idx(2));
                end else if (cyc > t + 13) begin
                    wif.w_ready = ($urandom_range(0, 3) != 0);
                end
            end else begin
                wif.w_ready = ($urandom_range(0, 3) != 0);
            end
            if (done) begin
                done_n++;
                done_c = cyc;
            end else if (done_n > 0) begin
                fin = 1'b1;
                chk("busy_after_done", int'(busy), 0);
            end
        end
        chk("run_finished", int'(fin), 1);
        chk("done_pulse_cycles", done_n, 1);
        chk("transfer_count", n_xfer - x0, c_count);
        chk("scoreboard_drained", exp_q.size(), 0);
        if (mode == 1) chk("done_latency", done_c - t, 254);
    endtask

    initial begin
        int t;
        int x0;
        int dn;
        wif.w_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_w_valid", int'(wif.w_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_w_out", int'(wif.w_out), 0);
        chk("rst_w_idx", int'(wif.w_idx), 0);

        do_run(1);
        do_run(2);

        // Reset in the middle of COMPUTE after k=20 was transferred.
        push_expected();
        x0 = n_xfer;
        dn = 0;
        @(posedge clock); #1;
        start       = 1'b1;
        wif.w_ready = 1'b1;
        t           = cyc;
        for (int i = 1; i <= 83; i++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (done) dn++;
            if (cyc == t + 83) begin
                chk("pre_reset_in_compute", int'(wif.w_valid), 0);
                reset = 1'b1;
                exp_q.delete();
            end
        end
        @(posedge clock); #1;
        chk("post_reset_w_valid", int'(wif.w_valid), 0);
        chk("post_reset_busy", int'(busy), 0);
        chk("post_reset_done", int'(done), 0);
        chk("reset_run_transfers", n_xfer - x0, 21);
        chk("reset_run_no_done", dn, 0);
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clock); #1;
        chk("reset_beats_start", int'(busy), 0);
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("idle_no_activity", int'(wif.w_valid), 0);

        do_run(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
